fifo_sync_ex: RTL and testbench
===============================

# fifo_sync_ex

Parametrised synchronous FIFO, the next generation of the project's byte FIFO. It buffers `DATA_WIDTH`-bit words between the RS232 receiver/transmitter and the host-side logic. It adds:
- arbitrary (non-power-of-2) depth
- occupancy count and programmable almost-full/almost-empty thresholds
- defined simultaneous push/pop
- overflow/underflow strobes
- an optional first-word-fall-through read mode

## Interface
- `DEPTH`, 3, number of storage words; legal range 2..1024, not required to be a power of 2
- `DATA_WIDTH`, 8, word width in bits
- `AF_LEVEL`, 2, `almost_full` asserts when count >= `AF_LEVEL`; legal range 1..`DEPTH`
- `AE_LEVEL`, 1, `almost_empty` asserts when count <= `AE_LEVEL`; legal range 0..`DEPTH`-1
- `clk`  in  1  single clock, all logic on rising edge
- `clear`  in  1  synchronous, active-low reset (0 = reset)
- `push`  in  1  write request, sampled each rising edge
- `pop`  in  1  read request, sampled each rising edge
- `in_data`  in  `DATA_WIDTH`  write data, sampled with `push`
- `out_data`  out  `DATA_WIDTH`  read data
- `out_valid`  out  1  `out_data` holds a valid word (meaning depends on mode)
- `count`  out  CW = clog2(`DEPTH`+1)  words stored
- `full`  out  1  count == `DEPTH`
- `empty`  out  1  count == 0
- `almost_full`  out  1  threshold flag (see `AF_LEVEL`)
- `almost_empty`  out  1  threshold flag (see `AE_LEVEL`)
- `pushed_last`  out  1  one-cycle pulse: an accepted push made the FIFO full
- `popped_last`  out  1  one-cycle pulse: an accepted pop made the FIFO empty
- `overflow`  out  1  one-cycle pulse: a push was rejected
- `underflow`  out  1  one-cycle pulse: a pop was rejected

## Operation
- Storage is a register array `mem[0..DEPTH-1]` with write pointer `wp`, read pointer `rp` and `count`.
- Pointer increment: if ptr == `DEPTH`-1 the pointer wraps to 0, else ptr+1. No power-of-2 masking.
- Push acceptance: `push_ok` = `push` & (!`full` | `pop_ok`).
- Pop acceptance: `pop_ok` = `pop` & !`empty`. A pop on an empty FIFO is rejected even when `push` is also high.
- Full + push + pop: both are accepted, count is unchanged, and the write lands in the slot freed by the read.
- Empty + push + pop: the push is accepted, the pop is rejected, `underflow` pulses, and count becomes 1.
- Count update: count_next = count + `push_ok` − `pop_ok`. All flags are registered and derived from count_next, so they are valid in the cycle after the edge.
- Strobes:
  - `pushed_last` = `push_ok` & (count_next == `DEPTH`) & (count != `DEPTH`)
  - `popped_last` = `pop_ok` & (count_next == 0)
  - `overflow` = `push` & !`push_ok`
  - `underflow` = `pop` & !`pop_ok`
- Reset (`clear` == 0 at an edge), state after the edge:
  - `wp` = `rp` = `count` = 0
  - `empty` = 1, `almost_empty` = 1
  - all other flags and strobes 0
  - `out_data` = 0, `out_valid` = 0
  - Reset overrides any push/pop in the same cycle and discards stored data. Reset mid-burst is legal.

## Timing
- Default (registered read) mode:
  - An accepted pop at edge N loads `out_data` with `mem[rp]` and sets `out_valid` = 1 from edge N.
  - `out_data` holds its value until the next accepted pop.
  - `out_valid` drops at the next edge without an accepted pop.
  - Read latency is 1 cycle.
- Write latency: a word pushed at edge N can be popped at edge N+1.
- `count` and all flags update at the same edge as the accepted operation. Strobes last exactly one cycle.

## Configuration
- `FIFO_FWFT_EN` defined: first-word-fall-through mode.
  - `out_data` = `mem[rp]` (combinational from the array); `out_valid` = !`empty`.
  - `pop` acknowledges the shown word. The next word, or `out_valid` = 0, appears after the edge.
  - Read latency is 0; a word pushed into an empty FIFO is visible one cycle after its push edge.
- `FIFO_FWFT_EN` undefined: registered read mode as described under Timing.
- Flags, strobes and acceptance rules are identical in both modes.

## Structure
- Shared package `fifo_pkg`:
  - function `clog2_f`
  - constant `FIFO_MAX_DEPTH` = 1024
  - parameter-check macros (elaboration-time error on an illegal `DEPTH`/`AF_LEVEL`/`AE_LEVEL`)
- Sub-module `fifo_wrap_ptr`:
  - parameter `DEPTH`
  - ports `clk`, `clear`, `inc`, `ptr`
  - wrap-around pointer, instantiated twice (`wp`, `rp`)

## Test plan
DEPTH=3, AF_LEVEL=2, AE_LEVEL=1, default mode unless noted.
- Reset → push 0xAC, then push 0x61 → count 1 then 2; `almost_full` = 1 after the second push; `pushed_last` = 0 throughout.
- From the previous state, pop twice → `out_data` = 0xAC, then 0x61, each one cycle after its pop; `popped_last` pulses on the second pop; `empty` = 1.
- Push 0x11, 0x39, 0x7D → `pushed_last` pulses on 0x7D; `full` = 1. A 4th push of 0xFF → `overflow` pulse, count stays 3. Then pop three times → 0x11, 0x39, 0x7D (exercises pointer wrap).
- When full, push 0x55 and pop simultaneously → pop returns the oldest word, count stays 3, 0x55 is read out last. When empty, push and pop simultaneously → `underflow` pulse, count = 1.
- Drive `clear` = 0 for one cycle with count = 2 while push = 1 → count = 0, `empty` = 1, `out_valid` = 0, and no strobe asserts.
- With `FIFO_FWFT_EN`, push 0xAC into an empty FIFO → `out_valid` = 1 and `out_data` = 0xAC before any pop; a pop → `out_valid` = 0 at the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the synchronous FIFO family.
//   clog2_f            ceiling log2, usable in constant expressions
//   FIFO_MAX_DEPTH     largest supported storage depth
//   FIFO_CHECK_PARAMS  generate-time legality check on DEPTH/AF_LEVEL/AE_LEVEL
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_CHECK_PARAMS(D, AF, AE) \
  if ((D) < 2 || (D) > fifo_pkg::FIFO_MAX_DEPTH) begin : g_bad_depth \
    $error("fifo: DEPTH must be in 2..1024"); \
  end \
  if ((AF) < 1 || (AF) > (D)) begin : g_bad_af \
    $error("fifo: AF_LEVEL must be in 1..DEPTH"); \
  end \
  if ((AE) < 0 || (AE) > (D) - 1) begin : g_bad_ae \
    $error("fifo: AE_LEVEL must be in 0..DEPTH-1"); \
  end

package fifo_pkg;

  localparam int FIFO_MAX_DEPTH = 1024;

  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer that wraps from DEPTH-1 to 0
// without relying on a power-of-2 depth.
//   clk    rising-edge clock
//   clear  synchronous active-low reset, pointer returns to 0
//   inc    advance the pointer by one slot
//   ptr    current slot index, 0..DEPTH-1
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int PW   = clog2_f(DEPTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (!clear) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == LAST) ptr <= '0;
      else             ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sync_ex.sv
// fifo_sync_ex: parametrised synchronous FIFO with arbitrary depth,
// occupancy count, threshold flags and one-cycle event strobes.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through reads;
// without it reads are registered (1-cycle latency).
//   clk            rising-edge clock
//   clear          synchronous active-low reset
//   push/in_data   write request and data
//   pop            read request
//   out_data       read data; out_valid qualifies it
//   count          words stored
//   full/empty     count == DEPTH / count == 0
//   almost_full    count >= AF_LEVEL
//   almost_empty   count <= AE_LEVEL
//   pushed_last    accepted push filled the FIFO
//   popped_last    accepted pop emptied the FIFO
//   overflow       push rejected
//   underflow      pop rejected
module fifo_sync_ex
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 2,
  parameter int AE_LEVEL   = 1,
  localparam int CW        = clog2_f(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  pushed_last,
  output logic                  popped_last,
  output logic                  overflow,
  output logic                  underflow
);

  `FIFO_CHECK_PARAMS(DEPTH, AF_LEVEL, AE_LEVEL)

  localparam int PW = clog2_f(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic                  push_ok;
  logic                  pop_ok;
  logic [CW-1:0]         count_next;

  // A push into a full FIFO is still taken when a pop frees a slot in the
  // same cycle; a pop on an empty FIFO is never taken, even alongside a push.
  always_comb begin
    pop_ok     = pop & ~empty;
    push_ok    = push & (~full | pop_ok);
    count_next = count;
    if (push_ok && !pop_ok)      count_next = count + 1'b1;
    else if (pop_ok && !push_ok) count_next = count - 1'b1;
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wp (
    .clk   (clk),
    .clear (clear),
    .inc   (push_ok),
    .ptr   (wp)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rp (
    .clk   (clk),
    .clear (clear),
    .inc   (pop_ok),
    .ptr   (rp)
  );

  // Stored data is not cleared on reset; count/pointers make it unreachable.
  always_ff @(posedge clk) begin
    if (clear && push_ok) mem[wp] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      pushed_last  <= 1'b0;
      popped_last  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      pushed_last  <= push_ok & (count_next == DEPTH_C) & (count != DEPTH_C);
      popped_last  <= pop_ok & (count_next == '0);
      overflow     <= push & ~push_ok;
      underflow    <= pop & ~pop_ok;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; gated to 0 while empty so reset state is clean.
  always_comb begin
    out_valid = ~empty;
    out_data  = empty ? '0 : mem[rp];
  end
`else
  always_ff @(posedge clk) begin
    if (!clear) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (pop_ok) begin
      out_data  <= mem[rp];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_ex.sv
module tb_fifo_sync_ex;
  import fifo_pkg::*;

  localparam int DEPTH = 3;
  localparam int DW    = 8;
  localparam int AF    = 2;
  localparam int AE    = 1;
  localparam int CW    = clog2_f(DEPTH + 1);

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [CW-1:0] count;
  logic          full, empty, almost_full, almost_empty;
  logic          pushed_last, popped_last, overflow, underflow;

  fifo_sync_ex #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .push         (push),
    .pop          (pop),
    .in_data      (in_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .pushed_last  (pushed_last),
    .popped_last  (popped_last),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a plain queue.
  logic [DW-1:0] mq[$];
  // Scoreboard of words expected on the read port.
  logic [DW-1:0] exp_q[$];

  int   e_count;
  bit   e_full, e_empty, e_af, e_ae, e_pl, e_ppl, e_ovf, e_udf, e_valid;
  logic [DW-1:0] e_hold;
  bit   armed = 0;
  bit   done = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and advance the model
  // to the state it must hold after the following rising edge.
  task automatic cycle(input bit clr, input bit psh, input bit pp, input logic [DW-1:0] d);
    int n, m;
    bit pop_ok, push_ok;
    logic [DW-1:0] w;
    @(negedge clk);
    clear   = clr;
    push    = psh;
    pop     = pp;
    in_data = d;
    if (!clr) begin
      mq.delete();
      e_count = 0; e_full = 0; e_empty = 1; e_af = 0; e_ae = 1;
      e_pl = 0; e_ppl = 0; e_ovf = 0; e_udf = 0; e_valid = 0;
      e_hold = '0;
    end else begin
      n       = mq.size();
      pop_ok  = pp && (n > 0);
      push_ok = psh && ((n < DEPTH) || pop_ok);
      if (pop_ok) begin
        w = mq.pop_front();
`ifndef FIFO_FWFT_EN
        exp_q.push_back(w);
        e_hold = w;
`endif
      end
      if (push_ok) mq.push_back(d);
      m       = mq.size();
      e_count = m;
      e_full  = (m == DEPTH);
      e_empty = (m == 0);
      e_af    = (m >= AF);
      e_ae    = (m <= AE);
      e_pl    = push_ok && (m == DEPTH) && (n != DEPTH);
      e_ppl   = pop_ok && (m == 0);
      e_ovf   = psh && !push_ok;
      e_udf   = pp && !pop_ok;
`ifdef FIFO_FWFT_EN
      e_valid = (m > 0);
      if (m > 0) exp_q.push_back(mq[0]);
`else
      e_valid = pop_ok;
`endif
    end
    armed = 1;
  endtask

  // Monitor: compares every flag each cycle and drains the scoreboard
  // whenever the DUT presents a valid word.
  always @(posedge clk) begin
    #1;
    if (armed && !done) begin
      chk("count", int'(count), e_count);
      chk("full", int'(full), int'(e_full));
      chk("empty", int'(empty), int'(e_empty));
      chk("almost_full", int'(almost_full), int'(e_af));
      chk("almost_empty", int'(almost_empty), int'(e_ae));
      chk("pushed_last", int'(pushed_last), int'(e_pl));
      chk("popped_last", int'(popped_last), int'(e_ppl));
      chk("overflow", int'(overflow), int'(e_ovf));
      chk("underflow", int'(underflow), int'(e_udf));
      chk("out_valid", int'(out_valid), int'(e_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          chk("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
      end else begin
`ifndef FIFO_FWFT_EN
        chk("out_data_hold", int'(out_data), int'(e_hold));
`endif
      end
      exp_q.delete();
    end
  end

  initial begin
    // Reset, then the directed sequences.
    cycle(0, 0, 0, 8'h00);
    cycle(0, 1, 1, 8'h5A);
    cycle(1, 1, 0, 8'hAC);
    cycle(1, 1, 0, 8'h61);
    cycle(1, 0, 1, 8'h00);
    cycle(1, 0, 1, 8'h00);
    cycle(1, 0, 0, 8'h00);
    cycle(1, 1, 0, 8'h11);
    cycle(1, 1, 0, 8'h39);
    cycle(1, 1, 0, 8'h7D);
    cycle(1, 1, 0, 8'hFF);
    cycle(1, 0, 1, 8'h00);
    cycle(1, 0, 1, 8'h00);
    cycle(1, 0, 1, 8'h00);
    cycle(1, 0, 1, 8'h00);
    cycle(1, 1, 0, 8'hA1);
    cycle(1, 1, 0, 8'hA2);
    cycle(1, 1, 0, 8'hA3);
    cycle(1, 1, 1, 8'h55);
    cycle(1, 0, 1, 8'h00);
    cycle(1, 0, 1, 8'h00);
    cycle(1, 0, 1, 8'h00);
    cycle(1, 1, 1, 8'h42);
    cycle(1, 1, 0, 8'h43);
    cycle(0, 1, 0, 8'h44);
    cycle(1, 0, 0, 8'h00);
    // Randomised traffic with occasional mid-burst resets.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 99) < 50),
            8'($urandom));
    end
    cycle(1, 0, 0, 8'h00);
    @(negedge clk);
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
